// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state/phase encodings and bus constants for the I2C controller
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        STOP
    } i2c_ctrl_state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } i2c_phase_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: quarter-period tick divider, bit-slot phase counter and SCL level
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int QTR_CYCLES = 4
) (
    input  logic       clk_400,
    input  logic       rst,
    input  logic       en,
    input  logic       start_cond,
    output logic       qtick,
    output i2c_phase_t phase,
    output logic       scl
);

    localparam int CW = $clog2(QTR_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    i2c_phase_t    phase_q, phase_d;

    // divider and phase only run while a transaction is active
    always_comb begin
        qtick   = en && cnt_q == CW'(QTR_CYCLES - 1);
        cnt_d   = (!en || qtick) ? '0 : cnt_q + 1'b1;
        phase_d = !en ? Q0 : qtick ? i2c_phase_t'(phase_q + 2'd1) : phase_q;
    end

    // counter and phase registers
    always_ff @(posedge clk_400) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // START holds SCL high first and drops it halfway; every other slot is low then high
    assign scl   = !en ? 1'b1 : start_cond ? !phase_q[1] : phase_q[1];
    assign phase = phase_q;

endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: single-master I2C transaction engine (START, addr+R/W, N data bytes, STOP)
module i2c_controller
    import i2c_pkg::*;
#(
    parameter int QTR_CYCLES  = 4,
    parameter int MAX_BYTES_W = 4
) (
    input  logic                   clk_400,
    input  logic                   rst,
    input  logic                   start,
    input  logic [6:0]             addr,
    input  logic                   rw,
    input  logic [MAX_BYTES_W-1:0] num_bytes,
    input  logic [7:0]             tx_data,
    output logic                   tx_req,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_error,
    output logic [3:0]             state_out,
    output logic                   SCL,
    inout  wire                    SDA
);

    i2c_ctrl_state_t        state_q, state_d;
    logic [7:0]             sh_q, sh_d;
    logic [2:0]             bit_q, bit_d;
    logic [MAX_BYTES_W-1:0] cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic                   samp_q, samp_d;
    logic                   ack_error_q, ack_error_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_req_q, tx_req_d;
    logic                   done_q, done_d;

    logic       qtick, smp, slot_end, last_bit, more, sda_in, sda_low;
    i2c_phase_t phase;

    i2c_scl_gen #(.QTR_CYCLES(QTR_CYCLES)) u_scl_gen (
        .clk_400    (clk_400),
        .rst        (rst),
        .en         (state_q != IDLE),
        .start_cond (state_q == START),
        .qtick      (qtick),
        .phase      (phase),
        .scl        (SCL)
    );

    assign smp      = qtick && phase == Q2;
    assign slot_end = qtick && phase == Q3;
    assign last_bit = bit_q == 3'd7;
    assign more     = cnt_q > MAX_BYTES_W'(1);
    assign sda_in   = SDA;

    // state register plus all datapath flops
    always_ff @(posedge clk_400) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            samp_q      <= 1'b0;
            ack_error_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            samp_q      <= samp_d;
            ack_error_q <= ack_error_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            done_q      <= done_d;
        end
    end

    // next state: leave IDLE on start, otherwise move only at the end of a bit slot
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            state_d = start ? START : IDLE;
        end else if (slot_end) begin
            case (state_q)
                START:     state_d = ADDR;
                ADDR:      state_d = last_bit ? ADDR_ACK : ADDR;
                ADDR_ACK:  state_d = (samp_q == I2C_NACK || cnt_q == '0) ? STOP : rw_q ? READ : WRITE;
                WRITE:     state_d = last_bit ? WRITE_ACK : WRITE;
                WRITE_ACK: state_d = (samp_q == I2C_ACK && more) ? WRITE : STOP;
                READ:      state_d = last_bit ? READ_ACK : READ;
                READ_ACK:  state_d = more ? READ : STOP;
                default:   state_d = IDLE;
            endcase
        end
    end

    // datapath: latch request, shift bits, track bytes, raise status pulses
    always_comb begin
        sh_d        = sh_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        samp_d      = smp ? sda_in : samp_q;
        ack_error_d = ack_error_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        done_d      = 1'b0;
        if (state_q == IDLE && start) begin
            sh_d        = {addr, rw};
            bit_d       = '0;
            cnt_d       = num_bytes;
            rw_d        = rw;
            ack_error_d = 1'b0;
        end
        if (tx_req_q) sh_d = tx_data;
        if (state_q == READ && smp) begin
            sh_d = {sh_q[6:0], sda_in};
            if (last_bit) begin
                rx_data_d  = {sh_q[6:0], sda_in};
                rx_valid_d = 1'b1;
            end
        end
        if (slot_end) begin
            if (state_q inside {ADDR, WRITE, READ}) bit_d = bit_q + 3'd1;
            if (state_q inside {ADDR, WRITE}) sh_d = {sh_q[6:0], 1'b0};
            if (state_q inside {ADDR_ACK, WRITE_ACK} && samp_q == I2C_NACK) ack_error_d = 1'b1;
            if (state_q inside {WRITE_ACK, READ_ACK}) cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
            if (state_d == WRITE && state_q != WRITE) tx_req_d = 1'b1;
            if (state_q == STOP) done_d = 1'b1;
        end
    end

    // SDA pull-down: first write cycle uses tx_data directly since it is latched at that edge
    always_comb begin
        sda_low = state_q == START
               || (state_q inside {ADDR, WRITE} && !(tx_req_q ? tx_data[7] : sh_q[7]))
               || (state_q == READ_ACK && more)
               || (state_q == STOP && phase != Q3);
    end

    assign SDA       = sda_low ? 1'b0 : 1'bz;
    assign tx_req    = tx_req_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign ack_error = ack_error_q;
    assign state_out = state_q;

endmodule
